mem_req_arbiter: RTL and testbench

Parametrised multi-port front end for the memory pipeline. It accepts memory requests from NUM_PORTS execute ports and buffers each port in its own FIFO. Requests are computed and dispatched round-robin to either the D-cache or the I-cache CACOP path, with cross-path mutual exclusion and a bounded number of outstanding requests. Responses merge onto one writeback channel, and responses that belong to requests squashed by a flush are dropped.

---
 rtl/mem_req_arbiter_pkg.sv | 26 ++
 rtl/mem_req_arbiter_if.sv | 52 +++++
 rtl/mem_req_fifo.sv | 41 ++++
 rtl/mem_req_arbiter.sv | 87 ++++++++
 tb/tb_mem_req_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// mem_pipe_pkg: shared widths, request-entry struct and arbitration helpers
package mem_pipe_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ROB_W = 6;
    localparam int MAX_PORTS = 32;
    typedef struct packed {
        logic [ADDR_W-1:0] vaddr;
        logic [DATA_W-1:0] wdata;
        logic [ROB_W-1:0]  rob_idx;
        logic              icacop;
    } req_entry_t;
    function automatic int cnt_w(input int max_out);
        return $clog2(max_out + 2);
    endfunction
    // First set bit at or after ptr, wrapping at n; -1 when none is set.
    function automatic int rr_pick(input logic [MAX_PORTS-1:0] cand, input int ptr, input int n);
        int idx;
        rr_pick = -1;
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            idx = ptr + i;
            if (idx >= n) idx -= n;
            if (i < n && cand[idx[$clog2(MAX_PORTS)-1:0]]) rr_pick = idx;
        end
    endfunction
endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: request, dispatch, response and writeback signals of the arbiter
interface mem_req_arbiter_if import mem_pipe_pkg::*; #(
    parameter int NUM_PORTS = 2,
    parameter int IMM_W = 12
);
    logic                        flush_i;
    logic [NUM_PORTS-1:0]        req_valid_i;
    logic [NUM_PORTS-1:0]        req_ready_o;
    logic [NUM_PORTS*ADDR_W-1:0] req_base_i;
    logic [NUM_PORTS*IMM_W-1:0]  req_imm_i;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata_i;
    logic [NUM_PORTS*ROB_W-1:0]  req_rob_idx_i;
    logic [NUM_PORTS-1:0]        req_icacop_i;
    logic                        dc_req_valid_o;
    logic                        dc_req_ready_i;
    logic [ADDR_W-1:0]           dc_req_vaddr_o;
    logic [DATA_W-1:0]           dc_req_wdata_o;
    logic [ROB_W-1:0]            dc_req_rob_idx_o;
    logic                        ic_req_valid_o;
    logic                        ic_req_ready_i;
    logic [ADDR_W-1:0]           ic_req_vaddr_o;
    logic [ROB_W-1:0]            ic_req_rob_idx_o;
    logic                        dc_rsp_valid_i;
    logic                        dc_rsp_ready_o;
    logic [ROB_W-1:0]            dc_rsp_rob_idx_i;
    logic [DATA_W-1:0]           dc_rsp_rdata_i;
    logic                        ic_rsp_valid_i;
    logic                        ic_rsp_ready_o;
    logic [ROB_W-1:0]            ic_rsp_rob_idx_i;
    logic                        wb_valid_o;
    logic                        wb_ready_i;
    logic [ROB_W-1:0]            wb_rob_idx_o;
    logic [DATA_W-1:0]           wb_data_o;
    logic                        wb_icacop_o;
    logic                        idle_o;
    modport slave (
        input  flush_i, req_valid_i, req_base_i, req_imm_i, req_wdata_i, req_rob_idx_i, req_icacop_i,
               dc_req_ready_i, ic_req_ready_i, dc_rsp_valid_i, dc_rsp_rob_idx_i, dc_rsp_rdata_i,
               ic_rsp_valid_i, ic_rsp_rob_idx_i, wb_ready_i,
        output req_ready_o, dc_req_valid_o, dc_req_vaddr_o, dc_req_wdata_o, dc_req_rob_idx_o,
               ic_req_valid_o, ic_req_vaddr_o, ic_req_rob_idx_o, dc_rsp_ready_o, ic_rsp_ready_o,
               wb_valid_o, wb_rob_idx_o, wb_data_o, wb_icacop_o, idle_o
    );
    modport master (
        output flush_i, req_valid_i, req_base_i, req_imm_i, req_wdata_i, req_rob_idx_i, req_icacop_i,
               dc_req_ready_i, ic_req_ready_i, dc_rsp_valid_i, dc_rsp_rob_idx_i, dc_rsp_rdata_i,
               ic_rsp_valid_i, ic_rsp_rob_idx_i, wb_ready_i,
        input  req_ready_o, dc_req_valid_o, dc_req_vaddr_o, dc_req_wdata_o, dc_req_rob_idx_o,
               ic_req_valid_o, ic_req_vaddr_o, ic_req_rob_idx_o, dc_rsp_ready_o, ic_rsp_ready_o,
               wb_valid_o, wb_rob_idx_o, wb_data_o, wb_icacop_o, idle_o
    );
endinterface

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: per-port request FIFO with wrap-bit pointers and synchronous clear
module mem_req_fifo import mem_pipe_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  req_entry_t wdata,
    output req_entry_t rdata,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    req_entry_t mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic do_push, do_pop;
    always_comb begin
        full = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
        empty = wr_ptr_q == rd_ptr_q;
        do_push = push & ~full;
        do_pop = pop & ~empty;
        wr_ptr_d = clr ? '0 : wr_ptr_q + PW'(do_push);
        rd_ptr_d = clr ? '0 : rd_ptr_q + PW'(do_pop);
        rdata = mem_q[rd_ptr_q[AW-1:0]];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin D-cache/CACOP dispatch with flush-aware response merging
module mem_req_arbiter import mem_pipe_pkg::*; #(
    parameter int NUM_PORTS = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int IMM_W = 12,
    parameter int IMM_SHIFT = 2,
    parameter int MAX_OUT = 4
) (
    input logic clk,
    input logic rst,
    mem_req_arbiter_if.slave bus
);
    localparam int CNT_W = cnt_w(MAX_OUT);
    localparam int PTR_W = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_PORTS - 1);
    req_entry_t enq [NUM_PORTS];
    req_entry_t head [NUM_PORTS];
    logic [NUM_PORTS-1:0] push, pop, full, empty, cand;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d, win;
    logic [CNT_W-1:0] dc_out_q, dc_out_d, ic_out_q, ic_out_d, drop_cnt_q, drop_cnt_d;
    logic any, dc_fire, ic_fire, dc_rsp_fire, ic_rsp_fire, dropping, dc_ok, ic_ok;
    int pick;
    assign dc_ok = (dc_out_q < MAX_CNT) && (ic_out_q == '0);
    assign ic_ok = (dc_out_q == '0) && (ic_out_q == '0);
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [IMM_W-1:0] imm;
        assign imm = bus.req_imm_i[p*IMM_W +: IMM_W];
        assign enq[p] = '{
            vaddr:   bus.req_base_i[p*ADDR_W +: ADDR_W] + ({{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm} << IMM_SHIFT),
            wdata:   bus.req_wdata_i[p*DATA_W +: DATA_W],
            rob_idx: bus.req_rob_idx_i[p*ROB_W +: ROB_W],
            icacop:  bus.req_icacop_i[p]
        };
        assign push[p] = bus.req_valid_i[p] & ~full[p] & ~bus.flush_i;
        assign cand[p] = ~empty[p] & (head[p].icacop ? ic_ok : dc_ok);
        mem_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk(clk), .rst(rst), .clr(bus.flush_i), .push(push[p]), .pop(pop[p]),
            .wdata(enq[p]), .rdata(head[p]), .full(full[p]), .empty(empty[p])
        );
    end
    always_comb begin
        pick = rr_pick(MAX_PORTS'(cand), int'(rr_ptr_q), NUM_PORTS);
        dropping = bus.flush_i | (drop_cnt_q != '0);
        any = (pick >= 0) & ~dropping;
        win = any ? PTR_W'(pick) : '0;
        bus.req_ready_o = ~full & {NUM_PORTS{~bus.flush_i}};
        bus.dc_req_valid_o = any & ~head[win].icacop;
        bus.dc_req_vaddr_o = head[win].vaddr;
        bus.dc_req_wdata_o = head[win].wdata;
        bus.dc_req_rob_idx_o = head[win].rob_idx;
        bus.ic_req_valid_o = any & head[win].icacop;
        bus.ic_req_vaddr_o = head[win].vaddr;
        bus.ic_req_rob_idx_o = head[win].rob_idx;
        dc_fire = bus.dc_req_valid_o & bus.dc_req_ready_i;
        ic_fire = bus.ic_req_valid_o & bus.ic_req_ready_i;
        pop = NUM_PORTS'(dc_fire | ic_fire) << win;
        rr_ptr_d = (dc_fire | ic_fire) ? (win == LAST ? '0 : win + 1'b1) : rr_ptr_q;
        // CACOP responses win the writeback slot; during a drop everything is swallowed.
        bus.ic_rsp_ready_o = bus.wb_ready_i | dropping;
        bus.dc_rsp_ready_o = (bus.wb_ready_i & ~bus.ic_rsp_valid_i) | dropping;
        ic_rsp_fire = bus.ic_rsp_valid_i & bus.ic_rsp_ready_o;
        dc_rsp_fire = bus.dc_rsp_valid_i & bus.dc_rsp_ready_o;
        bus.wb_valid_o = ~dropping & (bus.ic_rsp_valid_i | bus.dc_rsp_valid_i);
        bus.wb_icacop_o = bus.ic_rsp_valid_i;
        bus.wb_rob_idx_o = bus.ic_rsp_valid_i ? bus.ic_rsp_rob_idx_i : bus.dc_rsp_rob_idx_i;
        bus.wb_data_o = bus.ic_rsp_valid_i ? '0 : bus.dc_rsp_rdata_i;
        dc_out_d = dc_out_q + CNT_W'(dc_fire) - CNT_W'(dc_rsp_fire);
        ic_out_d = ic_out_q + CNT_W'(ic_fire) - CNT_W'(ic_rsp_fire);
        drop_cnt_d = bus.flush_i ? dc_out_q + ic_out_q - CNT_W'(dc_rsp_fire) - CNT_W'(ic_rsp_fire)
                   : drop_cnt_q - (dropping ? CNT_W'(dc_rsp_fire) + CNT_W'(ic_rsp_fire) : '0);
        bus.idle_o = (&empty) & (dc_out_q == '0) & (ic_out_q == '0) & (drop_cnt_q == '0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            dc_out_q <= '0;
            ic_out_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            dc_out_q <= dc_out_d;
            ic_out_q <= ic_out_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;
    import mem_pipe_pkg::*;
    localparam int NP = 2;
    localparam int IW = 12;
    logic clk = 1'b0;
    logic rst;
    int tests = 0;
    int fails = 0;
    int exp_rr [4] = '{20, 10, 21, 11};
    always #5 clk = ~clk;
    mem_req_arbiter_if #(.NUM_PORTS(NP), .IMM_W(IW)) bus ();
    mem_req_arbiter #(.NUM_PORTS(NP), .FIFO_DEPTH(4), .IMM_W(IW), .IMM_SHIFT(2), .MAX_OUT(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic set_req(input int p, input logic v, input logic [31:0] base, input logic [11:0] imm,
                           input logic [31:0] wd, input logic [5:0] rob, input logic ic);
        bus.req_valid_i[p] = v;
        bus.req_base_i[p*ADDR_W +: ADDR_W] = base;
        bus.req_imm_i[p*IW +: IW] = imm;
        bus.req_wdata_i[p*DATA_W +: DATA_W] = wd;
        bus.req_rob_idx_i[p*ROB_W +: ROB_W] = rob;
        bus.req_icacop_i[p] = ic;
    endtask
    task automatic dc_rsp(input logic v, input logic [5:0] rob, input logic [31:0] data);
        bus.dc_rsp_valid_i = v;
        bus.dc_rsp_rob_idx_i = rob;
        bus.dc_rsp_rdata_i = data;
    endtask
    task automatic ic_rsp(input logic v, input logic [5:0] rob);
        bus.ic_rsp_valid_i = v;
        bus.ic_rsp_rob_idx_i = rob;
    endtask
    initial begin
        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.req_valid_i = '0;
        bus.req_base_i = '0;
        bus.req_imm_i = '0;
        bus.req_wdata_i = '0;
        bus.req_rob_idx_i = '0;
        bus.req_icacop_i = '0;
        bus.dc_req_ready_i = 1'b0;
        bus.ic_req_ready_i = 1'b0;
        dc_rsp(1'b0, 6'd0, 32'd0);
        ic_rsp(1'b0, 6'd0);
        bus.wb_ready_i = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_idle", bus.idle_o, 1);
        chk("rst_ready", bus.req_ready_o, 2'b11);
        chk("rst_dc_valid", bus.dc_req_valid_o, 0);
        chk("rst_ic_valid", bus.ic_req_valid_o, 0);
        chk("rst_wb_valid", bus.wb_valid_o, 0);
        rst = 1'b0;
        tick();
        // negative immediate address computation and one-cycle dispatch latency
        set_req(0, 1'b1, 32'h1000, 12'hFFF, 32'h11, 6'd5, 1'b0);
        #1 chk("enq_ready", bus.req_ready_o, 2'b11);
        tick();
        bus.req_valid_i = '0;
        #1;
        chk("vaddr_neg_imm", bus.dc_req_vaddr_o, 32'h0FFC);
        chk("dc_valid_1cyc", bus.dc_req_valid_o, 1);
        chk("dc_rob", bus.dc_req_rob_idx_o, 5);
        chk("dc_wdata", bus.dc_req_wdata_o, 32'h11);
        chk("ic_valid_off", bus.ic_req_valid_o, 0);
        bus.dc_req_ready_i = 1'b1;
        tick();
        bus.dc_req_ready_i = 1'b0;
        #1;
        chk("popped", bus.dc_req_valid_o, 0);
        chk("busy", bus.idle_o, 0);
        dc_rsp(1'b1, 6'd5, 32'hABCD);
        #1;
        chk("wb_valid", bus.wb_valid_o, 1);
        chk("wb_rob", bus.wb_rob_idx_o, 5);
        chk("wb_data", bus.wb_data_o, 32'hABCD);
        chk("wb_icacop0", bus.wb_icacop_o, 0);
        chk("dc_rsp_ready", bus.dc_rsp_ready_o, 1);
        tick();
        dc_rsp(1'b0, 6'd0, 32'd0);
        #1 chk("idle_after_rsp", bus.idle_o, 1);
        // round robin: pointer is now 1, so port 1 goes first
        set_req(0, 1'b1, 32'h100, 12'h0, 32'h0, 6'd10, 1'b0);
        set_req(1, 1'b1, 32'h200, 12'h0, 32'h0, 6'd20, 1'b0);
        tick();
        set_req(0, 1'b1, 32'h104, 12'h0, 32'h0, 6'd11, 1'b0);
        set_req(1, 1'b1, 32'h204, 12'h0, 32'h0, 6'd21, 1'b0);
        tick();
        bus.req_valid_i = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rob", bus.dc_req_rob_idx_o, 20);
            chk("stall_vaddr", bus.dc_req_vaddr_o, 32'h200);
            tick();
        end
        bus.dc_req_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_valid", bus.dc_req_valid_o, 1);
            chk("rr_rob", bus.dc_req_rob_idx_o, 64'(exp_rr[i]));
            tick();
        end
        // CACOP waits for all four D-cache responses; D op behind it waits for ic_rsp
        set_req(0, 1'b1, 32'h2000, 12'h0, 32'h0, 6'd30, 1'b1);
        tick();
        set_req(0, 1'b1, 32'h3000, 12'h0, 32'h0, 6'd32, 1'b0);
        tick();
        bus.req_valid_i = '0;
        bus.ic_req_ready_i = 1'b1;
        #1;
        chk("max_out_dc_block", bus.dc_req_valid_o, 0);
        chk("max_out_ic_block", bus.ic_req_valid_o, 0);
        for (int i = 0; i < 4; i++) begin
            dc_rsp(1'b1, 6'(exp_rr[i]), 32'(i));
            #1;
            chk("drain_wb_rob", bus.wb_rob_idx_o, 64'(exp_rr[i]));
            chk("drain_ic_wait", bus.ic_req_valid_o, 0);
            tick();
        end
        dc_rsp(1'b0, 6'd0, 32'd0);
        #1;
        chk("cacop_valid", bus.ic_req_valid_o, 1);
        chk("cacop_vaddr", bus.ic_req_vaddr_o, 32'h2000);
        chk("cacop_rob", bus.ic_req_rob_idx_o, 30);
        chk("cacop_dc_off", bus.dc_req_valid_o, 0);
        tick();
        #1;
        chk("d_waits_ic", bus.dc_req_valid_o, 0);
        chk("one_cacop", bus.ic_req_valid_o, 0);
        ic_rsp(1'b1, 6'd30);
        #1;
        chk("ic_wb_valid", bus.wb_valid_o, 1);
        chk("ic_wb_icacop", bus.wb_icacop_o, 1);
        chk("ic_wb_rob", bus.wb_rob_idx_o, 30);
        chk("ic_wb_data0", bus.wb_data_o, 0);
        tick();
        ic_rsp(1'b0, 6'd0);
        #1;
        chk("d_after_ic", bus.dc_req_valid_o, 1);
        chk("d_after_ic_rob", bus.dc_req_rob_idx_o, 32);
        chk("d_after_ic_vaddr", bus.dc_req_vaddr_o, 32'h3000);
        tick();
        dc_rsp(1'b1, 6'd32, 32'd0);
        tick();
        dc_rsp(1'b0, 6'd0, 32'd0);
        #1 chk("idle_t3", bus.idle_o, 1);
        // fill port 1, fifth request refused, then drain in order
        bus.dc_req_ready_i = 1'b0;
        bus.ic_req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1, 1'b1, 32'h4000 + 32'(4 * i), 12'h0, 32'h0, 6'(40 + i), 1'b0);
            tick();
        end
        #1 chk("full_ready", bus.req_ready_o[1], 0);
        set_req(1, 1'b1, 32'h5000, 12'h0, 32'h0, 6'd44, 1'b0);
        tick();
        bus.req_valid_i = '0;
        bus.dc_req_ready_i = 1'b1;
        #1 chk("pop_no_lift", bus.req_ready_o[1], 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fifo_order_valid", bus.dc_req_valid_o, 1);
            chk("fifo_order_rob", bus.dc_req_rob_idx_o, 64'(40 + i));
            tick();
        end
        #1;
        chk("no_fifth", bus.dc_req_valid_o, 0);
        chk("ready_back", bus.req_ready_o, 2'b11);
        // flush with three outstanding
        bus.dc_req_ready_i = 1'b0;
        dc_rsp(1'b1, 6'd40, 32'd0);
        tick();
        dc_rsp(1'b0, 6'd0, 32'd0);
        set_req(0, 1'b1, 32'h6000, 12'h0, 32'h0, 6'd50, 1'b0);
        tick();
        bus.req_valid_i = '0;
        #1 chk("pre_flush_valid", bus.dc_req_valid_o, 1);
        bus.flush_i = 1'b1;
        #1;
        chk("flush_gate", bus.dc_req_valid_o, 0);
        chk("flush_ready", bus.req_ready_o, 2'b00);
        tick();
        bus.flush_i = 1'b0;
        #1;
        chk("post_flush_valid", bus.dc_req_valid_o, 0);
        chk("post_flush_busy", bus.idle_o, 0);
        bus.wb_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dc_rsp(1'b1, 6'(41 + i), 32'hDEAD);
            #1;
            chk("drop_ready", bus.dc_rsp_ready_o, 1);
            chk("drop_wb_off", bus.wb_valid_o, 0);
            tick();
        end
        dc_rsp(1'b0, 6'd0, 32'd0);
        bus.wb_ready_i = 1'b1;
        #1 chk("drop_done_idle", bus.idle_o, 1);
        set_req(0, 1'b1, 32'h0, 12'h004, 32'h0, 6'd60, 1'b0);
        bus.dc_req_ready_i = 1'b1;
        tick();
        bus.req_valid_i = '0;
        #1;
        chk("fresh_valid", bus.dc_req_valid_o, 1);
        chk("fresh_vaddr", bus.dc_req_vaddr_o, 32'h10);
        tick();
        bus.dc_req_ready_i = 1'b0;
        dc_rsp(1'b1, 6'd60, 32'h77);
        #1;
        chk("fresh_wb_valid", bus.wb_valid_o, 1);
        chk("fresh_wb_rob", bus.wb_rob_idx_o, 60);
        tick();
        dc_rsp(1'b0, 6'd0, 32'd0);
        // merge priority, then reset mid-stream
        set_req(1, 1'b1, 32'h7000, 12'h0, 32'h0, 6'd7, 1'b0);
        bus.dc_req_ready_i = 1'b1;
        tick();
        bus.req_valid_i = '0;
        tick();
        bus.dc_req_ready_i = 1'b0;
        ic_rsp(1'b1, 6'd33);
        dc_rsp(1'b1, 6'd7, 32'h55);
        #1;
        chk("merge_ic_first", bus.wb_icacop_o, 1);
        chk("merge_ic_rob", bus.wb_rob_idx_o, 33);
        chk("merge_dc_held", bus.dc_rsp_ready_o, 0);
        tick();
        ic_rsp(1'b0, 6'd0);
        #1;
        chk("merge_dc_valid", bus.wb_valid_o, 1);
        chk("merge_dc_next", bus.wb_icacop_o, 0);
        chk("merge_dc_rob", bus.wb_rob_idx_o, 7);
        chk("merge_dc_data", bus.wb_data_o, 32'h55);
        tick();
        dc_rsp(1'b0, 6'd0, 32'd0);
        set_req(0, 1'b1, 32'h8000, 12'h0, 32'h0, 6'd8, 1'b0);
        tick();
        bus.req_valid_i = '0;
        rst = 1'b1;
        tick();
        #1;
        chk("rst_mid_idle", bus.idle_o, 1);
        chk("rst_mid_dc_off", bus.dc_req_valid_o, 0);
        rst = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
